// File: rtl/montexp_ctrl.sv
// Modular exponentiation sequencer using left-to-right square-and-multiply.
// All arithmetic is issued to an external Montgomery multiplier over a start/done handshake.
module montexp_ctrl #(
    parameter int WID     = 256,
    parameter int EXP_WID = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WID-1:0]     base,
    input  logic [EXP_WID-1:0] exp,
    input  logic [WID-1:0]     one_m,
    input  logic [WID-1:0]     r2_m,
    output logic [WID-1:0]     mp_a,
    output logic [WID-1:0]     mp_b,
    output logic               mp_start,
    input  logic [WID-1:0]     mp_r,
    input  logic               mp_done,
    output logic [WID-1:0]     result,
    output logic               done,
    output logic               busy
);

    localparam int IDX_W = (EXP_WID > 1) ? $clog2(EXP_WID) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(EXP_WID - 1);
    localparam logic [WID-1:0]   ONE     = WID'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CIN,
        S_SQ,
        S_MUL,
        S_COUT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WID-1:0]     acc_q, acc_d;
    logic [WID-1:0]     bm_q, bm_d;
    logic [EXP_WID-1:0] e_q, e_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WID-1:0]     mp_a_q, mp_a_d;
    logic [WID-1:0]     mp_b_q, mp_b_d;
    logic               mp_start_q, mp_start_d;
    logic [WID-1:0]     result_q, result_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               op_done;

    // A done that coincides with our own issue cycle is a protocol violation and is dropped.
    assign op_done = mp_done && !mp_start_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            bm_q       <= '0;
            e_q        <= '0;
            idx_q      <= '0;
            mp_a_q     <= '0;
            mp_b_q     <= '0;
            mp_start_q <= 1'b0;
            result_q   <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            bm_q       <= bm_d;
            e_q        <= e_d;
            idx_q      <= idx_d;
            mp_a_q     <= mp_a_d;
            mp_b_q     <= mp_b_d;
            mp_start_q <= mp_start_d;
            result_q   <= result_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    // Operands for the next multiplication are loaded on the same edge that enters its state,
    // so they are already stable in the issue cycle and stay untouched until the matching done.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        bm_d       = bm_q;
        e_d        = e_q;
        idx_d      = idx_q;
        mp_a_d     = mp_a_q;
        mp_b_d     = mp_b_q;
        mp_start_d = 1'b0;
        result_d   = result_q;
        done_d     = 1'b0;
        busy_d     = busy_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d      = one_m;
                    e_d        = exp;
                    idx_d      = IDX_TOP;
                    mp_a_d     = base;
                    mp_b_d     = r2_m;
                    mp_start_d = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = S_CIN;
                end
            end
            S_CIN: begin
                if (op_done) begin
                    bm_d       = mp_r;
                    mp_a_d     = acc_q;
                    mp_b_d     = acc_q;
                    mp_start_d = 1'b1;
                    state_d    = S_SQ;
                end
            end
            S_SQ: begin
                if (op_done) begin
                    acc_d      = mp_r;
                    mp_a_d     = mp_r;
                    mp_start_d = 1'b1;
                    if (e_q[idx_q]) begin
                        mp_b_d  = bm_q;
                        state_d = S_MUL;
                    end else if (idx_q == '0) begin
                        mp_b_d  = ONE;
                        state_d = S_COUT;
                    end else begin
                        idx_d   = idx_q - 1'b1;
                        mp_b_d  = mp_r;
                        state_d = S_SQ;
                    end
                end
            end
            S_MUL: begin
                if (op_done) begin
                    acc_d      = mp_r;
                    mp_a_d     = mp_r;
                    mp_start_d = 1'b1;
                    if (idx_q == '0) begin
                        mp_b_d  = ONE;
                        state_d = S_COUT;
                    end else begin
                        idx_d   = idx_q - 1'b1;
                        mp_b_d  = mp_r;
                        state_d = S_SQ;
                    end
                end
            end
            S_COUT: begin
                if (op_done) begin
                    result_d = mp_r;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mp_a     = mp_a_q;
    assign mp_b     = mp_b_q;
    assign mp_start = mp_start_q;
    assign result   = result_q;
    assign done     = done_q;
    assign busy     = busy_q;

endmodule
